seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scanner with a tear-free image load handshake.
// Optional feature: define SEG_LZ_BLANK_EN to blank leading zero digits (digit 0 is never blanked).
module seg_scan_ctrl #(
  parameter int DWELL = 100000,
  parameter int GUARD = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_hex,
  input  logic [7:0]  load_dp,
  input  logic [7:0]  load_mask,
  output logic [7:0]  AN,
  output logic [7:0]  CX,
  output logic        frame_done
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam int CW = (DW > GW) ? DW : GW;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] GUARD_PEN  = (GUARD > 1) ? CW'(GUARD - 2) : '0;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_SCAN  = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t         state;
  logic [2:0]     d;
  logic [CW-1:0]  cnt;
  logic [31:0]    disp_hex, pend_hex, img_hex;
  logic [7:0]     disp_dp, pend_dp, img_dp;
  logic [7:0]     disp_mask, pend_mask, img_mask, eff_mask;
  logic           pend_valid;
  logic           commit;
  logic [2:0]     nd;
  logic [7:0]     an_next, cx_next;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  endfunction

`ifdef SEG_LZ_BLANK_EN
  // A digit is blanked while it and every digit above it show a bare zero.
  function automatic logic [7:0] lz_mask(input logic [31:0] hex, input logic [7:0] dp,
                                         input logic [7:0] mask);
    logic       z;
    logic [7:0] m;
    m = mask;
    z = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      z    = z & (hex[4*i +: 4] == 4'h0) & ~dp[i];
      m[i] = m[i] & ~z;
    end
    return m;
  endfunction
`endif

  // Image selection: a commit edge already shows the pending image on the next digit.
  always_comb begin
    commit   = pend_valid && (frame_done || (state == ST_OFF));
    img_hex  = commit ? pend_hex  : disp_hex;
    img_dp   = commit ? pend_dp   : disp_dp;
    img_mask = commit ? pend_mask : disp_mask;
`ifdef SEG_LZ_BLANK_EN
    eff_mask = lz_mask(img_hex, img_dp, img_mask);
`else
    eff_mask = img_mask;
`endif
    nd       = (state == ST_GUARD) ? (d + 3'd1) : 3'd0;
    an_next  = eff_mask[nd] ? ~(8'h01 << nd) : 8'hFF;
    cx_next  = {seg(img_hex[{nd, 2'b00} +: 4]), ~img_dp[nd]};
  end

  // Scan FSM with registered anode/segment/frame outputs.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      state      <= ST_OFF;
      d          <= 3'd0;
      cnt        <= '0;
      AN         <= 8'hFF;
      CX         <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          state      <= ST_SCAN;
          d          <= 3'd0;
          cnt        <= '0;
          AN         <= an_next;
          CX         <= cx_next;
          frame_done <= 1'b0;
        end
        ST_SCAN: begin
          if (cnt == DWELL_LAST) begin
            state      <= ST_GUARD;
            cnt        <= '0;
            AN         <= 8'hFF;
            CX         <= 8'hFF;
            frame_done <= (d == 3'd7) && (GUARD == 1);
          end else begin
            cnt        <= cnt + 1'b1;
            frame_done <= 1'b0;
          end
        end
        ST_GUARD: begin
          if (cnt == GUARD_LAST) begin
            state      <= ST_SCAN;
            d          <= nd;
            cnt        <= '0;
            AN         <= an_next;
            CX         <= cx_next;
            frame_done <= 1'b0;
          end else begin
            cnt        <= cnt + 1'b1;
            frame_done <= (d == 3'd7) && (cnt == GUARD_PEN);
          end
        end
        default: begin
          state      <= ST_OFF;
          d          <= 3'd0;
          cnt        <= '0;
          AN         <= 8'hFF;
          CX         <= 8'hFF;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

  // Load handshake: one pending slot, released only by a commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_hex   <= 32'h0;
      disp_dp    <= 8'h00;
      disp_mask  <= 8'h00;
      pend_hex   <= 32'h0;
      pend_dp    <= 8'h00;
      pend_mask  <= 8'h00;
      pend_valid <= 1'b0;
      load_ready <= 1'b1;
    end else if (commit) begin
      disp_hex   <= pend_hex;
      disp_dp    <= pend_dp;
      disp_mask  <= pend_mask;
      pend_valid <= 1'b0;
      load_ready <= 1'b1;
    end else if (load_valid && load_ready) begin
      pend_hex   <= load_hex;
      pend_dp    <= load_dp;
      pend_mask  <= load_mask;
      pend_valid <= 1'b1;
      load_ready <= 1'b0;
    end else begin
      pend_valid <= pend_valid;
      load_ready <= load_ready;
    end
  end

endmodule
